// File: rtl/chan_sum_pkg.sv
// Shared helpers for the chan_sum adder tree: level count, padded channel count,
// and the overflow counter width.
package chan_sum_pkg;

    localparam int OVF_CNT_W = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int pad_ch(input int n);
        return 1 << clog2(n);
    endfunction

endpackage

// File: rtl/chan_sum_level.sv
// One registered level of the adder tree: N_IN lanes in, N_IN/2 pairwise sums out.
module chan_sum_level
    import chan_sum_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int SUM_W = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic [N_IN*SUM_W-1:0]       in_data,
    output logic                        out_valid,
    output logic [(N_IN/2)*SUM_W-1:0]   out_data
);

    localparam int N_OUT = N_IN / 2;

    logic [N_OUT*SUM_W-1:0] sum_nxt;

    for (genvar j = 0; j < N_OUT; j++) begin : g_add
        assign sum_nxt[j*SUM_W +: SUM_W] = in_data[(2*j)*SUM_W +: SUM_W]
                                         + in_data[(2*j+1)*SUM_W +: SUM_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= sum_nxt;
        end
    end

endmodule

// File: rtl/chan_sum_pipe.sv
// Pipelined N-channel masked adder tree with valid/ready and overflow tracking.
// Define CHAN_SUM_SAT_EN to clamp out_sum on overflow instead of wrapping.
module chan_sum_pipe
    import chan_sum_pkg::*;
#(
    parameter int   N_CH   = 16,
    parameter int   W      = 23,
    parameter int   SIGNED = 0,
    localparam int  L      = clog2(N_CH),
    localparam int  SUM_W  = W + L
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_CH*W-1:0]     in_data,
    input  logic [N_CH-1:0]       ch_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_sum,
    output logic [SUM_W-1:0]      out_full,
    output logic                  out_ovf,
    output logic [OVF_CNT_W-1:0]  ovf_cnt
);

    localparam int N_P    = pad_ch(N_CH);
    localparam int TREE_W = (2*N_P - 1) * SUM_W;

    // All tree levels live in one flat bus; level i starts at this lane index.
    function automatic int lvl_off(input int i);
        return 2*N_P - ((2*N_P) >> i);
    endfunction

    logic                  en;
    logic [N_P*SUM_W-1:0]  s0_nxt;
    logic [N_P*SUM_W-1:0]  s0_q;
    logic                  s0_vld;
    wire  [TREE_W-1:0]     tree;
    wire  [L:0]            vld;

    // One global stall: nothing moves unless the output slot is free or draining.
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = vld[L];
    assign out_full  = tree[lvl_off(L)*SUM_W +: SUM_W];

    always_comb begin
        s0_nxt = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_mask[k]) begin
                if (SIGNED != 0) s0_nxt[k*SUM_W +: SUM_W] = SUM_W'($signed(in_data[k*W +: W]));
                else             s0_nxt[k*SUM_W +: SUM_W] = SUM_W'(in_data[k*W +: W]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vld <= 1'b0;
            s0_q   <= '0;
        end else if (en) begin
            s0_vld <= in_valid;
            s0_q   <= s0_nxt;
        end
    end

    assign tree[0 +: N_P*SUM_W] = s0_q;
    assign vld[0]               = s0_vld;

    for (genvar i = 1; i <= L; i++) begin : g_lvl
        localparam int OFF_I = lvl_off(i-1);
        localparam int OFF_O = lvl_off(i);
        localparam int N_I   = N_P >> (i-1);

        chan_sum_level #(.N_IN(N_I), .SUM_W(SUM_W)) u_lvl (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .in_valid  (vld[i-1]),
            .in_data   (tree[OFF_I*SUM_W +: N_I*SUM_W]),
            .out_valid (vld[i]),
            .out_data  (tree[OFF_O*SUM_W +: (N_I/2)*SUM_W])
        );
    end

    if (L == 0) begin : g_single
        assign out_sum = out_full[W-1:0];
        assign out_ovf = 1'b0;
    end else begin : g_final
        localparam int FOFF = lvl_off(L-1);

        logic [SUM_W-1:0] fin_nxt;
        logic [L:0]       top_bits;
        logic             ovf_nxt;
        logic [W-1:0]     sum_nxt;

        // Same sum the last level registers; out_sum/out_ovf are derived from it
        // so they land in the same cycle as out_full.
        assign fin_nxt  = tree[FOFF*SUM_W +: SUM_W] + tree[(FOFF+1)*SUM_W +: SUM_W];
        assign top_bits = fin_nxt[SUM_W-1:W-1];

        always_comb begin
            if (SIGNED != 0) ovf_nxt = !((&top_bits) || !(|top_bits));
            else             ovf_nxt = |fin_nxt[SUM_W-1:W];
`ifdef CHAN_SUM_SAT_EN
            if (ovf_nxt) begin
                if (SIGNED != 0) sum_nxt = fin_nxt[SUM_W-1] ? ~({W{1'b1}} >> 1) : ({W{1'b1}} >> 1);
                else             sum_nxt = '1;
            end else begin
                sum_nxt = fin_nxt[W-1:0];
            end
`else
            sum_nxt = fin_nxt[W-1:0];
`endif
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_sum <= '0;
                out_ovf <= 1'b0;
            end else if (en) begin
                out_sum <= sum_nxt;
                out_ovf <= ovf_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_cnt <= '0;
        else if (out_valid && out_ready && out_ovf && (ovf_cnt != '1))
            ovf_cnt <= ovf_cnt + 1'b1;
    end

endmodule

// File: tb/tb_chan_sum_pipe.sv
// Scoreboard bench: drives an unsigned and a signed chan_sum_pipe with the same stream.
module tb_chan_sum_pipe;

    localparam int N_CH  = 16;
    localparam int W     = 23;
    localparam int SUM_W = 27;
`ifdef CHAN_SUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam longint UMAX = (longint'(1) << W) - 1;
    localparam longint SMAX = (longint'(1) << (W-1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W-1));

    typedef struct packed {
        logic [W-1:0]     sum;
        logic [SUM_W-1:0] full;
        logic             ovf;
    } res_t;

    logic                clk, rst, in_valid, out_ready;
    logic [N_CH*W-1:0]   in_data;
    logic [N_CH-1:0]     ch_mask;
    logic                in_ready_u, out_valid_u, out_ovf_u;
    logic [W-1:0]        out_sum_u;
    logic [SUM_W-1:0]    out_full_u;
    logic [15:0]         ovf_cnt_u;
    logic                in_ready_s, out_valid_s, out_ovf_s;
    logic [W-1:0]        out_sum_s;
    logic [SUM_W-1:0]    out_full_s;
    logic [15:0]         ovf_cnt_s;

    int   checks = 0;
    int   fails  = 0;
    res_t qu[$];
    res_t qs[$];
    int   ecnt_u = 0;
    int   ecnt_s = 0;
    bit   hold   = 0;
    res_t hold_v;
    bit   done;

    chan_sum_pipe #(.N_CH(N_CH), .W(W), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_data(in_data), .ch_mask(ch_mask), .out_valid(out_valid_u),
        .out_ready(out_ready), .out_sum(out_sum_u), .out_full(out_full_u),
        .out_ovf(out_ovf_u), .ovf_cnt(ovf_cnt_u)
    );

    chan_sum_pipe #(.N_CH(N_CH), .W(W), .SIGNED(1)) u_sdut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .ch_mask(ch_mask), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_sum(out_sum_s), .out_full(out_full_s),
        .out_ovf(out_ovf_s), .ovf_cnt(ovf_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [N_CH*W-1:0] d, input logic [N_CH-1:0] m, input bit sgn);
        res_t         r;
        longint       acc, t;
        logic [W-1:0] c;
        acc = 0;
        for (int k = 0; k < N_CH; k++) begin
            if (m[k]) begin
                c = d[k*W +: W];
                if (sgn) acc += longint'($signed(c));
                else     acc += longint'(c);
            end
        end
        r.full = acc[SUM_W-1:0];
        r.ovf  = sgn ? ((acc > SMAX) || (acc < SMIN)) : (acc > UMAX);
        if (SAT && r.ovf) begin
            if (sgn) begin
                t     = (acc < 0) ? SMIN : SMAX;
                r.sum = t[W-1:0];
            end else begin
                r.sum = '1;
            end
        end else begin
            r.sum = acc[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [N_CH*W-1:0] fill(input logic [W-1:0] v);
        logic [N_CH*W-1:0] d;
        for (int k = 0; k < N_CH; k++) d[k*W +: W] = v;
        return d;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            chk("rst_vld_u", out_valid_u, 0);
            chk("rst_vld_s", out_valid_s, 0);
            qu.delete();
            qs.delete();
            ecnt_u = 0;
            ecnt_s = 0;
            hold   = 0;
        end else begin
            chk("cnt_u", ovf_cnt_u, ecnt_u);
            chk("cnt_s", ovf_cnt_s, ecnt_s);
            if (hold) begin
                chk("hold_vld", out_valid_u, 1);
                chk("hold_full", out_full_u, hold_v.full);
                chk("hold_sum", out_sum_u, hold_v.sum);
            end
            hold   = out_valid_u && !out_ready;
            hold_v = '{out_sum_u, out_full_u, out_ovf_u};
            if (out_valid_u && out_ready) begin
                chk("q_u_nonempty", qu.size() != 0, 1);
                if (qu.size() != 0) begin
                    e = qu.pop_front();
                    chk("sum_u", out_sum_u, e.sum);
                    chk("full_u", out_full_u, e.full);
                    chk("ovf_u", out_ovf_u, e.ovf);
                    if (e.ovf && ecnt_u < 16'hFFFF) ecnt_u++;
                end
            end
            if (out_valid_s && out_ready) begin
                chk("q_s_nonempty", qs.size() != 0, 1);
                if (qs.size() != 0) begin
                    e = qs.pop_front();
                    chk("sum_s", out_sum_s, e.sum);
                    chk("full_s", out_full_s, e.full);
                    chk("ovf_s", out_ovf_s, e.ovf);
                    if (e.ovf && ecnt_s < 16'hFFFF) ecnt_s++;
                end
            end
            if (in_valid && in_ready_u && in_ready_s) begin
                qu.push_back(model(in_data, ch_mask, 1'b0));
                qs.push_back(model(in_data, ch_mask, 1'b1));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [N_CH*W-1:0] d, input logic [N_CH-1:0] m);
        bit acc;
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        ch_mask  = m;
        do begin
            @(negedge clk);
            acc = in_ready_u && in_ready_s;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        chk("send_accept", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qu.size() != 0 || qs.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_done", n < 200, 1);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_CH*W-1:0] d;
        int lat;
        clk = 0; rst = 0; in_valid = 0; in_data = '0; ch_mask = '0; out_ready = 1;
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid_u, 0);
        chk("rst_out_sum", out_sum_u, 0);
        chk("rst_out_full", out_full_u, 0);
        chk("rst_out_ovf", out_ovf_u, 0);
        chk("rst_ovf_cnt", ovf_cnt_u, 0);
        rst = 0;
        #1 chk("rst_in_ready", in_ready_u, 1);
        @(posedge clk); #1;

        send(fill(23'h0), '1);
        drain();
        send(fill(23'h1), 16'hFFFF);
        send(fill(23'h1), 16'h00FF);
        drain();
        d = '0; d[0 +: W] = 23'h7FFFFF; d[W +: W] = 23'h1;
        send(d, '1);
        drain();
        chk("ovf_cnt_u_one", ovf_cnt_u, 1);
        chk("ovf_cnt_s_zero", ovf_cnt_s, 0);
        send(fill(23'h7FFFFF), 16'hFFFF);
        drain();

        // Back-to-back stream with a 3-cycle downstream stall mid-way.
        fork
            for (int i = 1; i <= 8; i++) begin
                d = '0; d[0 +: W] = W'(i);
                send(d, '1);
            end
            begin
                repeat (6) @(posedge clk);
                #2 out_ready = 0;
                repeat (3) @(posedge clk);
                #2 out_ready = 1;
            end
        join
        drain();

        // Random data, masks and back-pressure.
        done = 0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    for (int k = 0; k < N_CH; k++) d[k*W +: W] = W'($urandom);
                    send(d, N_CH'($urandom));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1;
            end
        join
        drain();

        // Reset with samples in flight.
        for (int i = 0; i < 3; i++) begin
            d = '0; d[0 +: W] = W'(20 + i);
            send(d, '1);
        end
        rst = 1;
        #1;
        chk("midrst_out_valid", out_valid_u, 0);
        chk("midrst_ovf_cnt", ovf_cnt_u, 0);
        chk("midrst_out_full", out_full_u, 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        d = '0; d[0 +: W] = 23'd5;
        in_valid = 1; in_data = d; ch_mask = '1;
        @(posedge clk); #1;
        in_valid = 0;
        lat = 1;
        while (!out_valid_u && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 5);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/chan_sum_pipe.md
# chan_sum_pipe

Parametrised, pipelined N-channel adder tree with valid/ready flow control. It generalises the fixed 16×23-bit combinational summer and adds three things: configurable width, channel count and signedness; a per-sample channel mask; an overflow flag with a running overflow count. It sits between the per-microphone delay/weight stage and the beamformer output path, summing one sample per channel per accepted transfer.

## Interface
Parameters:
- N_CH, 16, number of input channels (≥1; non-power-of-two is zero-padded to the next power of two)
- W, 23, per-channel sample width in bits
- SIGNED, 0, 0 = unsigned two's-complement-free sum, 1 = signed two's complement
- L (localparam), clog2(N_CH), number of adder levels; 0 when N_CH=1
- SUM_W (localparam), W+L, full-precision sum width

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample vector valid
- in_ready  out  1  block can accept input this cycle
- in_data  in  N_CH*W  channel k at [k*W +: W]
- ch_mask  in  N_CH  bit k=1 includes channel k; sampled with in_data
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  W  W-bit result (wrapped or saturated, see Configuration)
- out_full  out  SUM_W  full-precision sum, never overflows
- out_ovf  out  1  out_full not representable in W bits (unsigned or signed per SIGNED)
- ovf_cnt  out  16  count of delivered results with out_ovf=1, saturates at 16'hFFFF

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Stage 0 registers the masked, width-extended channels to SUM_W (zero- or sign-extended per SIGNED); masked channels become 0.
- Stages 1..L: each registers the pairwise sums of the previous stage; stage L also registers out_sum and out_ovf, computed from its own sum.
- Global stall: en = !out_valid || out_ready; in_ready = en; every stage, including valid bits, advances only when en=1. Bubbles are not collapsed.
- Overflow, unsigned: out_ovf = |out_full[SUM_W-1:W]. Signed: upper L+1 bits not all equal.
- ovf_cnt increments on each output transfer with out_ovf=1 and holds at 16'hFFFF.
- N_CH=1: no adder levels; out_ovf is constantly 0.

## Timing
- Latency LAT = L+1 cycles from input transfer to out_valid, assuming no stall (N_CH=16: 5 cycles).
- Throughput: one sample per cycle while out_ready=1.
- With out_ready low, out_valid/out_sum/out_full/out_ovf hold stable; no sample is lost or duplicated, and order is preserved.
- Reset values: out_valid=0, out_sum=0, out_full=0, out_ovf=0, ovf_cnt=0, all stage valids 0; in_ready=1 once reset is released.
- Reset asserted mid-stream discards every in-flight sample immediately; out_valid=0 while rst is high.
- in_data/ch_mask are don't-care when in_valid=0.

## Configuration
- CHAN_SUM_SAT_EN defined: when out_ovf=1, out_sum clamps. Unsigned clamps to all-ones. Signed clamps to max positive or min negative according to the sign of out_full.
- Undefined: out_sum = out_full[W-1:0], a plain wrap.
- out_full, out_ovf and ovf_cnt behave identically in both builds.

## Structure
- chan_sum_pkg holds the clog2 function, the padded-channel-count function, and the ovf_cnt width constant (16).
- One sub-module, chan_sum_level: a single registered adder level. It is parametrised by input count and SUM_W, carries a valid bit and an enable, and is instantiated L times in a generate loop.

## Test plan
- N_CH=16, W=23, unsigned, mask all ones, all channels 0 → at cycle 5: out_sum=0, out_full=0, out_ovf=0.
- All channels 1, mask 16'hFFFF → out_sum=16, out_ovf=0. Same data with mask 16'h00FF → out_sum=8.
- ch0=23'h7FFFFF, ch1=1, others 0 → out_full=27'h0800000, out_ovf=1. out_sum=0 without CHAN_SUM_SAT_EN and 23'h7FFFFF with it. ovf_cnt becomes 1 on the output transfer.
- SIGNED=1, all 16 channels 23'h7FFFFF (−1) → out_sum=−16 (23'h7FFFF0), out_ovf=0.
- Stream 8 back-to-back samples 1..8 (ch0 only), holding out_ready low for 3 cycles mid-stream → outputs 1..8 in order, none dropped, and outputs stable while stalled.
- Assert rst for one cycle with 3 samples in flight → out_valid=0 and ovf_cnt=0 immediately; the next post-reset input emerges after exactly 5 cycles.
